// File: rtl/simple_fetch_if.sv
// simple_fetch_if: bundles the PC-block, instruction-memory and decode-side
// signals of the fetch front end.
//   pc / pcStall / redirect           : branch/PC block handshake
//   imemReq / imemAddr / imemGnt      : instruction-memory request channel
//   imemRvalid / imemRdata            : instruction-memory response channel
//   instrValid / instrReady / instr / instrPc : decode-side valid/ready stream
// master: the fetch unit.  slave: the surrounding environment.
interface simple_fetch_if #(
  parameter int unsigned ADDR_SIZE  = 20,
  parameter int unsigned INSTR_SIZE = 32
);
  logic [ADDR_SIZE-1:0]  pc;
  logic                  pcStall;
  logic                  redirect;
  logic                  imemReq;
  logic [ADDR_SIZE-1:0]  imemAddr;
  logic                  imemGnt;
  logic                  imemRvalid;
  logic [INSTR_SIZE-1:0] imemRdata;
  logic                  instrValid;
  logic                  instrReady;
  logic [INSTR_SIZE-1:0] instr;
  logic [ADDR_SIZE-1:0]  instrPc;

  modport master (
    input  pc, redirect, imemGnt, imemRvalid, imemRdata, instrReady,
    output pcStall, imemReq, imemAddr, instrValid, instr, instrPc
  );

  modport slave (
    output pc, redirect, imemGnt, imemRvalid, imemRdata, instrReady,
    input  pcStall, imemReq, imemAddr, instrValid, instr, instrPc
  );
endinterface

// File: rtl/simple_fetch.sv
// simple_fetch: instruction fetch front end. Issues one instruction-memory
// read per PC value, buffers responses with their fetch address in a small
// FIFO and presents them to decode. A redirect squashes buffered and
// in-flight fetches.
// Ports:
//   clk    : clock, all state updates on the rising edge
//   reset  : synchronous active-high reset
//   fetch  : simple_fetch_if.master (PC, imem request/response, decode stream)
module simple_fetch #(
  parameter int unsigned ADDR_SIZE  = 20,
  parameter int unsigned INSTR_SIZE = 32,
  parameter int unsigned DEPTH      = 2
) (
  input  logic           clk,
  input  logic           reset,
  simple_fetch_if.master fetch
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t                 r_state;
  logic [ADDR_SIZE-1:0]   r_inflight_pc;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [CNT_W-1:0]       r_count;
  logic [INSTR_SIZE-1:0]  r_mem_instr [DEPTH];
  logic [ADDR_SIZE-1:0]   r_mem_pc    [DEPTH];

  logic w_req;
  logic w_grant;
  logic w_push;
  logic w_valid;
  logic w_pop;

  // Request only with FIFO room; a redirect masks the request so the stale PC is never fetched
  assign w_req   = !reset && (r_state == S_REQ) && !fetch.redirect &&
                   (r_count < CNT_W'(DEPTH));
  assign w_grant = w_req && fetch.imemGnt;
  assign w_push  = !reset && (r_state == S_WAIT) && fetch.imemRvalid && !fetch.redirect;
  assign w_valid = !reset && (r_count != '0);
  assign w_pop   = w_valid && fetch.instrReady;

  // PC block advances on a grant and always loads on a redirect; held during reset
  assign fetch.pcStall    = reset || (!w_grant && !fetch.redirect);
  assign fetch.imemReq    = w_req;
  assign fetch.imemAddr   = fetch.pc;
  assign fetch.instrValid = w_valid;
  assign fetch.instr      = r_mem_instr[r_rd_ptr];
  assign fetch.instrPc    = r_mem_pc[r_rd_ptr];

  // Fetch state machine and FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_REQ;
      r_inflight_pc <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_grant) begin
            r_state       <= S_WAIT;
            r_inflight_pc <= fetch.pc;
          end
        end
        S_WAIT: begin
          // A response arriving with the redirect completes the outstanding
          // read (it is dropped, not pushed), so nothing is left to wait for.
          if (fetch.imemRvalid) begin
            r_state <= S_REQ;
          end else if (fetch.redirect) begin
            r_state <= S_DROP;
          end
        end
        S_DROP: begin
          if (fetch.imemRvalid) begin
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_REQ;
      endcase

      // Flush wins over any simultaneous push or pop
      if (fetch.redirect) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // FIFO storage, unreset: contents are only observed while the count says valid
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_instr[r_wr_ptr] <= fetch.imemRdata;
      r_mem_pc[r_wr_ptr]    <= r_inflight_pc;
    end
  end

endmodule

// File: tb/tb_simple_fetch.sv
// tb_simple_fetch: directed vector table, hand-written redirect/reset
// sequences and a randomized run against a queue-based reference model.
module tb_simple_fetch;
  localparam int unsigned AW    = 20;
  localparam int unsigned IW    = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned NVEC  = 22;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  simple_fetch_if #(.ADDR_SIZE(AW), .INSTR_SIZE(IW)) bus ();

  simple_fetch #(.ADDR_SIZE(AW), .INSTR_SIZE(IW), .DEPTH(DEPTH)) u_dut (
    .clk   (clk),
    .reset (reset),
    .fetch (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Sampled DUT outputs for the current cycle
  logic          s_req, s_stall, s_valid;
  logic [IW-1:0] s_instr;
  logic [AW-1:0] s_ipc, s_addr;
  // Address of the most recent granted request (what memory will answer)
  logic [AW-1:0] mem_addr;

  typedef struct {
    logic          rst, gnt, rv, rdy;
    logic          e_req, e_stall, e_valid;
    logic [IW-1:0] e_instr;
    logic [AW-1:0] e_ipc, e_addr;
  } vec_t;
  vec_t tbl [NVEC];

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
  } entry_t;

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return 32'hA000_0000 + IW'(a);
  endfunction

  function automatic vec_t mk(input logic rst, gnt, rv, rdy, er, es, ev,
                              input logic [IW-1:0] ei, input logic [AW-1:0] ep, ea);
    vec_t v;
    v.rst = rst; v.gnt = gnt; v.rv = rv; v.rdy = rdy;
    v.e_req = er; v.e_stall = es; v.e_valid = ev;
    v.e_instr = ei; v.e_ipc = ep; v.e_addr = ea;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs at negedge, sample outputs, then after the edge
  // advance the PC block and memory address latch.
  task automatic drive(input logic rst, gnt, rv, junk, rdy, redir, input logic [AW-1:0] tgt);
    @(negedge clk);
    reset          = rst;
    bus.imemGnt    = gnt;
    bus.imemRvalid = rv;
    bus.imemRdata  = rv ? (junk ? 32'hDEAD_BEEF : mem_word(mem_addr)) : '0;
    bus.instrReady = rdy;
    bus.redirect   = redir;
    #1;
    s_req   = bus.imemReq;
    s_stall = bus.pcStall;
    s_valid = bus.instrValid;
    s_instr = bus.instr;
    s_ipc   = bus.instrPc;
    s_addr  = bus.imemAddr;
    @(posedge clk);
    #1;
    if (s_req && gnt) mem_addr = bus.pc;
    if (rst)              bus.pc = '0;
    else if (redir)       bus.pc = tgt;
    else if (!s_stall)    bus.pc = bus.pc + AW'(1);
  endtask

  task automatic expect_out(input string tag, input logic e_req, e_stall, e_valid,
                            input logic [IW-1:0] e_instr, input logic [AW-1:0] e_ipc, e_addr);
    check({tag, ".imemReq"},    32'(s_req),   32'(e_req));
    check({tag, ".pcStall"},    32'(s_stall), 32'(e_stall));
    check({tag, ".instrValid"}, 32'(s_valid), 32'(e_valid));
    if (e_valid) begin
      check({tag, ".instr"},   s_instr,     e_instr);
      check({tag, ".instrPc"}, 32'(s_ipc),  32'(e_ipc));
    end
    if (e_req) check({tag, ".imemAddr"}, 32'(s_addr), 32'(e_addr));
  endtask

  // Reference model state for the random run
  entry_t        q[$];
  bit            outst, squashed;
  logic [AW-1:0] out_addr;
  bit            mem_pend;
  int            mem_cnt;

  initial begin
    logic          rst, gnt, rv, rdy, redir, e_req, e_stall, e_valid;
    logic [AW-1:0] tgt, cur_pc;
    entry_t        head;

    reset = 1'b1; bus.pc = '0; bus.redirect = 1'b0; bus.imemGnt = 1'b0;
    bus.imemRvalid = 1'b0; bus.imemRdata = '0; bus.instrReady = 1'b0;
    mem_addr = '0; outst = 0; squashed = 0; out_addr = '0; mem_pend = 0; mem_cnt = 0;

    //              rst gnt rv rdy | req stall valid instr         ipc      addr
    tbl[0]  = mk(1, 1, 0, 1,  0, 1, 0, 32'h0,          20'h0, 20'h0);
    tbl[1]  = mk(1, 1, 0, 1,  0, 1, 0, 32'h0,          20'h0, 20'h0);
    tbl[2]  = mk(0, 1, 0, 1,  1, 0, 0, 32'h0,          20'h0, 20'h0);
    tbl[3]  = mk(0, 0, 1, 1,  0, 1, 0, 32'h0,          20'h0, 20'h0);
    tbl[4]  = mk(0, 1, 0, 1,  1, 0, 1, 32'hA000_0000,  20'h0, 20'h1);
    tbl[5]  = mk(0, 0, 1, 1,  0, 1, 0, 32'h0,          20'h0, 20'h0);
    tbl[6]  = mk(0, 1, 0, 1,  1, 0, 1, 32'hA000_0001,  20'h1, 20'h2);
    tbl[7]  = mk(0, 0, 1, 0,  0, 1, 0, 32'h0,          20'h0, 20'h0);
    tbl[8]  = mk(0, 1, 0, 0,  1, 0, 1, 32'hA000_0002,  20'h2, 20'h3);
    tbl[9]  = mk(0, 0, 1, 0,  0, 1, 1, 32'hA000_0002,  20'h2, 20'h0);
    tbl[10] = mk(0, 1, 0, 0,  0, 1, 1, 32'hA000_0002,  20'h2, 20'h0);
    tbl[11] = mk(0, 1, 0, 0,  0, 1, 1, 32'hA000_0002,  20'h2, 20'h0);
    tbl[12] = mk(0, 1, 0, 1,  0, 1, 1, 32'hA000_0002,  20'h2, 20'h0);
    tbl[13] = mk(0, 1, 0, 0,  1, 0, 1, 32'hA000_0003,  20'h3, 20'h4);
    tbl[14] = mk(0, 0, 1, 1,  0, 1, 1, 32'hA000_0003,  20'h3, 20'h0);
    tbl[15] = mk(0, 0, 0, 1,  1, 1, 1, 32'hA000_0004,  20'h4, 20'h5);
    tbl[16] = mk(0, 0, 0, 1,  1, 1, 0, 32'h0,          20'h0, 20'h5);
    tbl[17] = mk(0, 0, 0, 1,  1, 1, 0, 32'h0,          20'h0, 20'h5);
    tbl[18] = mk(0, 1, 0, 1,  1, 0, 0, 32'h0,          20'h0, 20'h5);
    tbl[19] = mk(0, 0, 0, 1,  0, 1, 0, 32'h0,          20'h0, 20'h0);
    tbl[20] = mk(0, 0, 1, 1,  0, 1, 0, 32'h0,          20'h0, 20'h0);
    tbl[21] = mk(0, 0, 0, 1,  1, 1, 1, 32'hA000_0005,  20'h5, 20'h6);

    // Reset, streaming, backpressure and grant delay
    for (int i = 0; i < int'(NVEC); i++) begin
      drive(tbl[i].rst, tbl[i].gnt, tbl[i].rv, 1'b0, tbl[i].rdy, 1'b0, '0);
      expect_out($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_stall, tbl[i].e_valid,
                 tbl[i].e_instr, tbl[i].e_ipc, tbl[i].e_addr);
    end

    // Redirect in REQ with a grant: masked, PC loads 0x10
    drive(0, 1, 0, 0, 1, 1, 20'h00010); expect_out("rdq0", 0, 0, 0, '0, '0, '0);
    drive(0, 1, 0, 0, 1, 0, '0);        expect_out("rdq1", 1, 0, 0, '0, '0, 20'h00010);
    // Redirect in WAIT, stale 0xDEADBEEF response two cycles later
    drive(0, 0, 0, 0, 1, 1, 20'h00400); expect_out("rdw0", 0, 0, 0, '0, '0, '0);
    drive(0, 0, 0, 0, 1, 0, '0);        expect_out("rdw1", 0, 1, 0, '0, '0, '0);
    drive(0, 0, 1, 1, 1, 0, '0);        expect_out("rdw2", 0, 1, 0, '0, '0, '0);
    drive(0, 0, 0, 0, 1, 0, '0);        expect_out("rdw3", 1, 1, 0, '0, '0, 20'h00400);
    drive(0, 1, 0, 0, 1, 0, '0);        expect_out("rdw4", 1, 0, 0, '0, '0, 20'h00400);
    drive(0, 0, 1, 0, 0, 0, '0);        expect_out("rdw5", 0, 1, 0, '0, '0, '0);
    // One entry buffered; redirect + response + pop together
    drive(0, 1, 0, 0, 0, 0, '0);        expect_out("co0", 1, 0, 1, 32'hA000_0400, 20'h00400, 20'h00401);
    drive(0, 0, 1, 0, 1, 1, 20'h00800); expect_out("co1", 0, 0, 1, 32'hA000_0400, 20'h00400, '0);
    drive(0, 0, 0, 0, 1, 0, '0);        expect_out("co2", 1, 1, 0, '0, '0, 20'h00800);
    // Reset while a request is outstanding with one entry buffered
    drive(0, 1, 0, 0, 0, 0, '0);        expect_out("rs0", 1, 0, 0, '0, '0, 20'h00800);
    drive(0, 0, 1, 0, 0, 0, '0);        expect_out("rs1", 0, 1, 0, '0, '0, '0);
    drive(0, 1, 0, 0, 0, 0, '0);        expect_out("rs2", 1, 0, 1, 32'hA000_0800, 20'h00800, 20'h00801);
    drive(1, 1, 0, 0, 1, 0, '0);        expect_out("rs3", 0, 1, 0, '0, '0, '0);
    drive(0, 0, 0, 0, 1, 0, '0);        expect_out("rs4", 1, 1, 0, '0, '0, 20'h0);

    // Randomized run against the reference model, starting from reset
    for (int k = 0; k < 3000; k++) begin
      rst   = (k == 0) || ($urandom_range(0, 199) == 0);
      gnt   = ($urandom_range(0, 3) != 0);
      rdy   = ($urandom_range(0, 2) != 0);
      redir = !rst && ($urandom_range(0, 11) == 0);
      tgt   = AW'($urandom);
      rv    = !rst && mem_pend && (mem_cnt == 1);
      cur_pc  = bus.pc;
      e_req   = !rst && !redir && !outst && (q.size() < int'(DEPTH));
      e_stall = rst || (!(e_req && gnt) && !redir);
      e_valid = !rst && (q.size() != 0);

      drive(rst, gnt, rv, 1'b0, rdy, redir, tgt);

      check("rnd.imemReq",    32'(s_req),   32'(e_req));
      check("rnd.pcStall",    32'(s_stall), 32'(e_stall));
      check("rnd.instrValid", 32'(s_valid), 32'(e_valid));
      if (e_valid) begin
        head = q[0];
        check("rnd.instr",   s_instr,    head.instr);
        check("rnd.instrPc", 32'(s_ipc), 32'(head.pc));
      end
      if (e_req) check("rnd.imemAddr", 32'(s_addr), 32'(cur_pc));

      // Model: in-order queue of fetched words, one outstanding read at most
      if (rst) begin
        q.delete(); outst = 0; squashed = 0;
      end else begin
        if (e_valid && rdy) void'(q.pop_front());
        if (rv) begin
          if (!squashed && !redir) q.push_back({mem_word(out_addr), out_addr});
          outst = 0;
        end
        if (redir) begin
          q.delete();
          squashed = outst;
        end
        if (e_req && gnt) begin
          outst = 1; squashed = 0; out_addr = cur_pc;
        end
      end

      // Memory: answers each grant after 1..3 cycles
      if (rst) begin
        mem_pend = 0;
      end else begin
        if (rv) mem_pend = 0;
        else if (mem_pend) mem_cnt--;
        if (s_req && gnt) begin
          mem_pend = 1;
          mem_cnt  = int'($urandom_range(1, 3));
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
